// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port RAM between the VGA display
// prefetch engine (feeding a small pixel FIFO) and a host read/write port.
module vga_fb_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int FRAME_PIXELS = 307200,
    parameter int FIFO_DEPTH   = 8,
    parameter int LOW_WM       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 2;

    typedef enum logic [1:0] {H_IDLE, H_ISSUE, H_RDWAIT} h_state_e;

    h_state_e          h_state_q, h_state_d;
    logic              run_q;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic              dsp_p1_q, dsp_p2_q;   // display read presented / data returning
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    level_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [7:0]        mem_wdata_q;
    logic [7:0]        pix_data_q;
    logic              pix_valid_q, underflow_q;
    logic [7:0]        host_rdata_q;

    logic [OCC_W-1:0]  occ;
    logic              fifo_empty, disp_elig, host_ok, gnt_disp, gnt_host, push, pop;

    // Arbitration: urgent display beats host, host beats non-urgent display.
    always_comb begin
        occ        = OCC_W'(level_q) + OCC_W'(dsp_p1_q) + OCC_W'(dsp_p2_q);
        fifo_empty = (level_q == '0);
        disp_elig  = run_q && !frame_start
                     && (fetch_addr_q < ADDR_W'(FRAME_PIXELS))
                     && (occ < OCC_W'(FIFO_DEPTH));
        host_ok    = host_req && (h_state_q == H_IDLE);
        gnt_disp   = disp_elig && ((occ < OCC_W'(LOW_WM)) || !host_ok);
        gnt_host   = host_ok && !gnt_disp;
        // Stale returns are dropped by clearing the read pipe on frame_start.
        push       = dsp_p2_q && !frame_start;
        pop        = pix_req && !fifo_empty && !frame_start;
    end

    // Host transaction FSM: next state and the ack pulse.
    always_comb begin
        h_state_d = h_state_q;
        host_ack  = 1'b0;
        case (h_state_q)
            H_IDLE:   if (gnt_host) h_state_d = H_ISSUE;
            H_ISSUE: begin
                if (mem_we_q) begin
                    host_ack  = 1'b1;
                    h_state_d = H_IDLE;
                end else begin
                    h_state_d = H_RDWAIT;
                end
            end
            H_RDWAIT: begin
                host_ack  = 1'b1;
                h_state_d = H_IDLE;
            end
            default:  h_state_d = H_IDLE;
        endcase
    end

    // Host state register and read-data holding register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_state_q    <= H_IDLE;
            host_rdata_q <= '0;
        end else begin
            h_state_q <= h_state_d;
            if (h_state_q == H_RDWAIT) host_rdata_q <= mem_rdata;
        end
    end

    // Read data goes out in the cycle it returns, then stays held.
    assign host_rdata = (h_state_q == H_RDWAIT) ? mem_rdata : host_rdata_q;

    // Registered RAM command: one op per cycle, address holds when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else if (gnt_disp) begin
            mem_addr_q <= fetch_addr_q;
            mem_we_q   <= 1'b0;
        end else if (gnt_host) begin
            mem_addr_q  <= host_addr;
            mem_we_q    <= host_we;
            mem_wdata_q <= host_wdata;
        end else begin
            mem_we_q <= 1'b0;
        end
    end

    // Prefetch engine: run flag, fetch address and in-flight read tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q        <= 1'b0;
            fetch_addr_q <= '0;
            dsp_p1_q     <= 1'b0;
            dsp_p2_q     <= 1'b0;
        end else if (frame_start) begin
            run_q        <= 1'b1;
            fetch_addr_q <= '0;
            dsp_p1_q     <= 1'b0;
            dsp_p2_q     <= 1'b0;
        end else begin
            dsp_p1_q <= gnt_disp;
            dsp_p2_q <= dsp_p1_q;
            if (gnt_disp) fetch_addr_q <= fetch_addr_q + 1'b1;
        end
    end

    // Pixel FIFO pointers and level; frame_start flushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (frame_start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    // Pixel FIFO storage.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
    end

    // Pixel output stage and sticky underflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pix_valid_q <= pix_req && !frame_start;
            if (pop)                           pix_data_q <= fifo_mem[rd_ptr_q];
            else if (pix_req && !frame_start)  pix_data_q <= 8'h00;
            if (frame_start)                   underflow_q <= 1'b0;
            else if (pix_req && fifo_empty)    underflow_q <= 1'b1;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: 64-entry RAM model, pixel and host scoreboards,
// a table of host reads run against a full-rate pixel stream, and directed
// sequences for reset, underflow, fill, stale-drop and reset-abort cases.
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 19;
    localparam int FP     = 16;

    logic              clk = 1'b0;
    logic              reset, frame_start, pix_req;
    logic [7:0]        pix_data;
    logic              pix_valid, underflow;
    logic              host_req, host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata, host_rdata;
    logic              host_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.ADDR_W(ADDR_W), .FRAME_PIXELS(FP), .FIFO_DEPTH(8), .LOW_WM(2)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pix_req(pix_req),
        .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Initial RAM contents: RAM[i] = i inside the frame, i*7 beyond it.
    function automatic logic [7:0] ref_val(input int a);
        return (a < FP) ? 8'(a) : 8'(a * 7);
    endfunction

    logic [7:0] ram [64];
    logic       ram_load;

    // Synchronous RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 64; i++) ram[i] <= ref_val(i);
        end else if (mem_we) begin
            ram[mem_addr[5:0]] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr[5:0]];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       is_rd;
        logic [7:0] rdata;
    } host_exp_t;

    logic [7:0] pix_q [$];
    host_exp_t  host_q [$];
    int         pix_idx = 0;

    // Output monitor: pops the scoreboards when the DUT produces results.
    always @(negedge clk) begin
        if (reset) begin
            if (pix_valid) begin
                if (pix_q.size() == 0) check("pix_unexpected", 1, 0);
                else check("pix_data", pix_data, pix_q.pop_front());
            end
            if (host_ack) begin
                if (host_q.size() == 0) check("host_ack_unexpected", 1, 0);
                else begin
                    host_exp_t e;
                    e = host_q.pop_front();
                    if (e.is_rd) check("host_rdata", host_rdata, e.rdata);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse;
        frame_start = 1'b1;
        pix_idx     = 0;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pix_pulse;
        pix_req = 1'b1;
        pix_q.push_back(ref_val(pix_idx));
        pix_idx++;
        tick();
        pix_req = 1'b0;
    endtask

    // Issues one host op, waits (bounded) for its ack, reports latency from grant.
    task automatic host_op(input logic we, input int addr, input logic [7:0] wd,
                           input logic [7:0] exp, output int lat,
                           output logic a_we, output logic [ADDR_W-1:0] a_addr,
                           output logic [7:0] a_wdata);
        host_exp_t e;
        logic got;
        got        = 1'b0;
        lat        = -1;
        a_we       = 1'b0;
        a_addr     = '0;
        a_wdata    = '0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = ADDR_W'(addr);
        host_wdata = wd;
        e.is_rd    = !we;
        e.rdata    = exp;
        host_q.push_back(e);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (host_ack) begin
                lat     = c;
                got     = 1'b1;
                a_we    = mem_we;
                a_addr  = mem_addr;
                a_wdata = mem_wdata;
                break;
            end
        end
        if (!got) begin
            check("host_ack_timeout", 0, 1);
            void'(host_q.pop_back());
        end
        @(posedge clk);
        #1;
        host_req = 1'b0;
        host_we  = 1'b0;
    endtask

    task automatic wait_drain;
        for (int c = 0; c < 100 && (pix_q.size() != 0 || host_q.size() != 0); c++) tick();
        check("pix_q_left", pix_q.size(), 0);
        check("host_q_left", host_q.size(), 0);
    endtask

    typedef struct {
        logic       we;
        int         addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int                lat;
        logic              a_we;
        logic [ADDR_W-1:0] a_addr;
        logic [7:0]        a_wdata;
        int                acks;

        vecs[0] = '{1'b0, 5,  8'h00, 8'h05};
        vecs[1] = '{1'b0, 20, 8'h00, 8'h8C};
        vecs[2] = '{1'b0, 33, 8'h00, 8'hE7};
        vecs[3] = '{1'b0, 63, 8'h00, 8'hB9};
        vecs[4] = '{1'b0, 0,  8'h00, 8'h00};
        vecs[5] = '{1'b0, 15, 8'h00, 8'h0F};
        vecs[6] = '{1'b0, 48, 8'h00, 8'h50};
        vecs[7] = '{1'b0, 11, 8'h00, 8'h0B};

        reset = 1'b0; frame_start = 1'b0; pix_req = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        ram_load = 1'b1;
        repeat (3) @(negedge clk);
        ram_load = 1'b0;
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_underflow", underflow, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) tick();

        // Pixel requests before any frame_start: FIFO empty, underflow.
        for (int k = 0; k < 3; k++) begin
            pix_req = 1'b1;
            pix_q.push_back(8'h00);
            tick();
        end
        pix_req = 1'b0;
        tick();
        @(negedge clk);
        check("underflow_set", underflow, 1);
        check("halted_mem_addr", mem_addr, 0);
        check("halted_mem_we", mem_we, 0);
        @(posedge clk); #1;

        // frame_start: underflow clears, fetch runs 0..7 then stops.
        frame_pulse();
        @(negedge clk);
        check("underflow_cleared", underflow, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("fill_mem_addr", mem_addr, k);
            check("fill_mem_we", mem_we, 0);
        end
        repeat (8) @(negedge clk);
        check("fill_stopped_addr", mem_addr, 7);
        @(posedge clk); #1;

        // Drain the whole frame at one pixel every 4 cycles.
        for (int k = 0; k < FP; k++) begin
            pix_pulse();
            repeat (3) tick();
        end
        wait_drain();
        check("drain_underflow", underflow, 0);
        check("drain_last_addr", mem_addr, FP - 1);

        // Refill, then host write and read back while the FIFO is full.
        frame_pulse();
        repeat (14) tick();
        host_op(1'b1, 5, 8'hA5, 8'h00, lat, a_we, a_addr, a_wdata);
        check("wr_latency", lat, 1);
        check("wr_mem_we", a_we, 1);
        check("wr_mem_addr", a_addr, 5);
        check("wr_mem_wdata", a_wdata, 8'hA5);
        host_op(1'b0, 5, 8'h00, 8'hA5, lat, a_we, a_addr, a_wdata);
        check("rd_latency", lat, 2);
        host_op(1'b1, 5, 8'h05, 8'h00, lat, a_we, a_addr, a_wdata);

        // Back-to-back host reads against a pixel request every cycle.
        fork
            begin
                int                l2;
                logic              w2;
                logic [ADDR_W-1:0] ad2;
                logic [7:0]        wd2;
                for (int i = 0; i < 8; i++)
                    host_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, l2, w2, ad2, wd2);
            end
            begin
                for (int k = 0; k < FP; k++) begin
                    pix_req = 1'b1;
                    pix_q.push_back(ref_val(pix_idx));
                    pix_idx++;
                    tick();
                end
                pix_req = 1'b0;
            end
        join
        wait_drain();
        check("hammer_underflow", underflow, 0);

        // frame_start with two display reads in flight: returns are dropped.
        frame_pulse();
        repeat (14) tick();
        pix_pulse();
        pix_pulse();
        tick();
        frame_start = 1'b1;
        pix_req     = 1'b1;
        pix_idx     = 0;
        tick();
        frame_start = 1'b0;
        pix_req     = 1'b0;
        @(negedge clk);
        check("fs_pix_valid", pix_valid, 0);
        check("fs_old_addr", mem_addr, 9);
        @(negedge clk);
        check("fs_restart_addr0", mem_addr, 0);
        @(negedge clk);
        check("fs_restart_addr1", mem_addr, 1);
        @(posedge clk); #1;
        repeat (14) tick();
        for (int k = 0; k < 3; k++) begin
            pix_pulse();
            tick();
        end
        wait_drain();

        // Reset in the middle of a host read: no ack ever arrives.
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = ADDR_W'(20);
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("abort_mem_we", mem_we, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_host_ack", host_ack, 0);
        check("abort_pix_valid", pix_valid, 0);
        @(posedge clk); #1;
        host_req = 1'b0;
        reset    = 1'b1;
        acks     = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (host_ack) acks++;
        end
        check("abort_no_ack", acks, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two requesters: the VGA pixel path (hard real-time) and a host port used by the image-processing side (read/write).
- Contains a display prefetch engine that fetches sequential addresses into a small pixel FIFO, which the VGA controller drains at one pixel per pix_req.
- Sits between VGA_Controller and the frame-buffer RAM. Runs on the 100 MHz system clock; the VGA controller issues pix_req once per 25 MHz pixel slot during active video.

Parameters:
ADDR_W, 19, frame-buffer address width
FRAME_PIXELS, 307200, pixels per frame (640x480); the fetch counter wraps to 0 only on frame_start
FIFO_DEPTH, 8, pixel FIFO entries (power of 2, >=4)
LOW_WM, 2, when FIFO level plus in-flight reads is below this, the display fetch is urgent

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low (0 = reset)
frame_start  in  1  one-cycle pulse at the start of vertical blanking
pix_req  in  1  VGA consumes one pixel this cycle
pix_data  out  8  RGB332 pixel, registered
pix_valid  out  1  pix_data valid (cycle after pix_req)
underflow  out  1  sticky: pix_req arrived with the FIFO empty
host_req  in  1  host transaction request; held with its fields until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  8  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  8  read data, valid with host_ack
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data; 1-cycle latency from mem_addr

Behaviour:
- Reset (async assert, synchronous release): all outputs 0; FIFO empty; fetch address 0; no reads in flight; underflow 0; fetch engine is halted until the first frame_start.
- Exactly one RAM op per cycle. All mem_* outputs are registered, so an op is granted in cycle N, presented in N+1, and its data returns in N+2.
- Display op is eligible when the engine is running, fetch_addr < FRAME_PIXELS, and fifo_level + inflight < FIFO_DEPTH.
- Grant priority per cycle:
  1) display, if eligible and fifo_level + inflight < LOW_WM;
  2) host, if host_req is high and no host op is outstanding;
  3) display, if eligible;
  4) idle (mem_we = 0, mem_addr holds its value).
- Display read: fetch_addr increments by 1 after each grant. The returned data is pushed into the FIFO when it arrives.
- Host write: mem_we = 1 for one cycle; host_ack pulses in the same cycle mem_we is high.
- Host read: host_ack pulses and host_rdata is captured when the data returns (grant + 2).
- Only one host op may be outstanding; the next host_req is sampled the cycle after host_ack.
- Host FSM states:
  - H_IDLE -> H_ISSUE on grant.
  - H_ISSUE -> H_IDLE for a write (with ack).
  - H_ISSUE -> H_RDWAIT for a read; H_RDWAIT -> H_IDLE with ack.
- Pixel pop: pix_req with the FIFO non-empty pops the head. On the next cycle pix_data = head and pix_valid = 1.
- Pixel underflow: pix_req with the FIFO empty gives pix_valid = 1, pix_data = 8'h00, and sets underflow.
- A push and a pop in the same cycle leave fifo_level unchanged. A push with the FIFO full is impossible by the eligibility rule; the verification engineer asserts it never occurs.
- frame_start handling:
  - Flushes the FIFO, sets fetch_addr = 0, clears underflow, and starts the engine.
  - Tags in-flight display reads as stale so their data is dropped.
  - Ignores any pix_req in the same cycle (no pop, pix_valid = 0).
  - Outstanding host ops are unaffected.
- When fetch_addr reaches FRAME_PIXELS, display fetch stops. The host has the RAM exclusively until the next frame_start.
- Reset asserted mid-transaction aborts everything; no host_ack is issued for the aborted op.

Test Plan:
- Reset, then frame_start with FRAME_PIXELS = 16, RAM[i] = i, no pix_req -> mem_addr steps 0..7, then fetch stops with FIFO full (level 8); underflow = 0.
- After the fill, pix_req every 4th cycle for 16 pops -> pix_data = 0x00..0x0F in order with pix_valid each time; fetch resumes up to addr 15 then stops; underflow = 0.
- Host write addr 5 = 0xA5 while the FIFO is full -> mem_we = 1 at addr 5 one cycle after the grant, host_ack in the same cycle; a following host read of addr 5 -> host_ack with host_rdata = 0xA5 two cycles after its grant.
- Host hammers reads back-to-back while pix_req runs every cycle -> display wins whenever level + inflight < 2; no underflow over 16 pixels; every host read is eventually acked.
- pix_req held with FIFO empty (no frame_start after reset) -> pix_valid = 1, pix_data = 0x00, underflow = 1; a later frame_start clears it to 0.
- frame_start while 2 display reads are in flight -> both returns are discarded, FIFO level = 0, next mem_addr = 0, and the first popped pixel = RAM[0].
